// File: rtl/key_sched_ctrl.sv
// Two-round 16-bit key schedule controller: serial byte key load, one time-shared
// key_gen stage for both rounds, and a round-key read port.

module key_gen (
    input  logic [15:0] input_key,
    input  logic [7:0]  round_constant,
    output logic [15:0] output_key
);
    logic [7:0] w0;
    logic [7:0] w1;
    logic [7:0] sub;
    logic [7:0] w2;

    // 4-bit substitution box applied per nibble
    function automatic logic [3:0] sbox(input logic [3:0] n);
        case (n)
            4'h0: sbox = 4'h9;
            4'h1: sbox = 4'h4;
            4'h2: sbox = 4'hA;
            4'h3: sbox = 4'hB;
            4'h4: sbox = 4'hD;
            4'h5: sbox = 4'h1;
            4'h6: sbox = 4'h8;
            4'h7: sbox = 4'h5;
            4'h8: sbox = 4'h6;
            4'h9: sbox = 4'h2;
            4'hA: sbox = 4'h0;
            4'hB: sbox = 4'h3;
            4'hC: sbox = 4'hC;
            4'hD: sbox = 4'hE;
            4'hE: sbox = 4'hF;
            default: sbox = 4'h7;
        endcase
    endfunction

    // Rotate the low word by one nibble, substitute, then fold in the round constant
    assign w0         = input_key[15:8];
    assign w1         = input_key[7:0];
    assign sub        = {sbox(w1[3:0]), sbox(w1[7:4])};
    assign w2         = w0 ^ round_constant ^ sub;
    assign output_key = {w2, w2 ^ w1};
endmodule

module key_sched_ctrl #(
    parameter logic [7:0] RCON1 = 8'h80,
    parameter logic [7:0] RCON2 = 8'h30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_valid,
    input  logic [7:0]  load_byte,
    output logic        load_ready,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        rk_valid,
    input  logic [1:0]  rk_sel,
    output logic [15:0] rk_out
);
    localparam int unsigned KEY_W  = 16;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {IDLE, LOAD_LO, READY, R1, R2} state_t;

    state_t             state;
    logic [KEY_W-1:0]   k0;
    logic [KEY_W-1:0]   k1;
    logic [KEY_W-1:0]   k2;
    logic [KEY_W-1:0]   gen_in;
    logic [KEY_W-1:0]   gen_out;
    logic [BYTE_W-1:0]  gen_rcon;
    logic               xfer;

    // A pending start in READY wins over a byte offered in the same cycle
    assign load_ready = (state == IDLE) || (state == LOAD_LO) || ((state == READY) && !start);
    assign xfer       = load_valid && load_ready;

    // Round-stage inputs come only from registered state
    assign gen_in   = (state == R2) ? k1 : k0;
    assign gen_rcon = (state == R2) ? RCON2 : RCON1;

    key_gen u_key_gen (
        .input_key      (gen_in),
        .round_constant (gen_rcon),
        .output_key     (gen_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            k0       <= '0;
            k1       <= '0;
            k2       <= '0;
            rk_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (xfer) begin
                        k0[15:8] <= load_byte;
                        rk_valid <= 1'b0;
                        state    <= LOAD_LO;
                    end
                end
                LOAD_LO: begin
                    if (xfer) begin
                        k0[7:0] <= load_byte;
                        state   <= READY;
                    end
                end
                READY: begin
                    if (start) begin
                        busy  <= 1'b1;
                        state <= R1;
                    end else if (xfer) begin
                        k0[15:8] <= load_byte;
                        rk_valid <= 1'b0;
                        state    <= LOAD_LO;
                    end
                end
                R1: begin
                    k1    <= gen_out;
                    state <= R2;
                end
                R2: begin
                    k2       <= gen_out;
                    rk_valid <= 1'b1;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= READY;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        rk_out = '0;
        case (rk_sel)
            2'd0:    rk_out = k0;
            2'd1:    rk_out = k1;
            2'd2:    rk_out = k2;
            default: rk_out = '0;
        endcase
    end
endmodule
